// File: rtl/imag_sram_arbiter_if.sv
// Requester and SRAM-side bus bundle for the imaginary-part SRAM arbiter.
// Ports: req/wea/addr/wdata in, gnt/rvalid/rdata out, two SRAM ports.
interface imag_sram_arbiter_if;
   logic [2:0]  req;
   logic [11:0] wea;
   logic [47:0] addr;
   logic [95:0] wdata;
   logic [2:0]  gnt;
   logic [2:0]  rvalid;
   logic [95:0] rdata;
   logic [3:0]  sram_wea0;
   logic [15:0] sram_addr0;
   logic [31:0] sram_wdata0;
   logic [31:0] sram_rdata0;
   logic [3:0]  sram_wea1;
   logic [15:0] sram_addr1;
   logic [31:0] sram_wdata1;
   logic [31:0] sram_rdata1;

   modport slave (
      input  req, wea, addr, wdata,
      input  sram_rdata0, sram_rdata1,
      output gnt, rvalid, rdata,
      output sram_wea0, sram_addr0, sram_wdata0,
      output sram_wea1, sram_addr1, sram_wdata1
   );

   modport master (
      output req, wea, addr, wdata,
      output sram_rdata0, sram_rdata1,
      input  gnt, rvalid, rdata,
      input  sram_wea0, sram_addr0, sram_wdata0,
      input  sram_wea1, sram_addr1, sram_wdata1
   );
endinterface

// File: rtl/imag_sram_arbiter.sv
// Rotating-priority arbiter sharing a dual-port 480x32 SRAM among 3 requesters.
// Ports: clk, rst (sync, active high), bus (slave modport: requester + SRAM side).
module imag_sram_arbiter #(
   parameter int DEPTH = 480,
   parameter int NREQ  = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   imag_sram_arbiter_if.slave   bus
);
   logic [1:0]  r_ptr;
   logic [2:0]  r_rvalid;
   logic [2:0]  r_psel;

   logic [15:0] w_addr  [3];
   logic [3:0]  w_wea   [3];
   logic [31:0] w_wdata [3];
   logic [1:0]  w_o0, w_o1, w_o2;
   logic        w_a_vld, w_b_vld;
   logic [1:0]  w_a, w_b, w_last;
   logic [2:0]  w_gnt;
   logic [15:0] w_addr0;
   logic [95:0] w_rdata;

   function automatic logic [1:0] f_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Same word with at least one writer cannot share a cycle.
   function automatic logic f_conf(input logic [1:0] x, input logic [1:0] y);
      return (w_addr[x] == w_addr[y]) && ((|w_wea[x]) || (|w_wea[y]));
   endfunction

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         w_addr[i]  = bus.addr[16*i +: 16];
         w_wea[i]   = bus.wea[4*i +: 4];
         w_wdata[i] = bus.wdata[32*i +: 32];
      end
   end

   assign w_o0 = r_ptr;
   assign w_o1 = f_inc(r_ptr);
   assign w_o2 = f_inc(w_o1);

   // A = first requester in rotation order; B = next non-conflicting one.
   always_comb begin
      w_a_vld = 1'b0;
      w_a     = 2'd0;
      w_b_vld = 1'b0;
      w_b     = 2'd0;
      if (!rst) begin
         if (bus.req[w_o0]) begin
            w_a_vld = 1'b1;
            w_a     = w_o0;
            if (bus.req[w_o1] && !f_conf(w_o0, w_o1)) begin
               w_b_vld = 1'b1;
               w_b     = w_o1;
            end else if (bus.req[w_o2] && !f_conf(w_o0, w_o2)) begin
               w_b_vld = 1'b1;
               w_b     = w_o2;
            end
         end else if (bus.req[w_o1]) begin
            w_a_vld = 1'b1;
            w_a     = w_o1;
            if (bus.req[w_o2] && !f_conf(w_o1, w_o2)) begin
               w_b_vld = 1'b1;
               w_b     = w_o2;
            end
         end else if (bus.req[w_o2]) begin
            w_a_vld = 1'b1;
            w_a     = w_o2;
         end
      end
   end

   assign w_gnt  = (w_a_vld ? (3'b001 << w_a) : 3'b000)
                 | (w_b_vld ? (3'b001 << w_b) : 3'b000);
   assign w_last = w_b_vld ? w_b : w_a;

   assign w_addr0         = w_a_vld ? w_addr[w_a] : 16'd0;
   assign bus.gnt         = w_gnt;
   assign bus.sram_addr0  = w_addr0;
   assign bus.sram_wea0   = w_a_vld ? w_wea[w_a] : 4'd0;
   assign bus.sram_wdata0 = w_a_vld ? w_wdata[w_a] : 32'd0;
   // Idle port 1 shadows port 0 so its implicit rewrite cannot clobber a write.
   assign bus.sram_addr1  = w_b_vld ? w_addr[w_b] : w_addr0;
   assign bus.sram_wea1   = w_b_vld ? w_wea[w_b] : 4'd0;
   assign bus.sram_wdata1 = w_b_vld ? w_wdata[w_b] : 32'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr    <= 2'd0;
         r_rvalid <= 3'd0;
         r_psel   <= 3'd0;
      end else begin
         if (w_a_vld) r_ptr <= f_inc(w_last);
         for (int i = 0; i < 3; i++) begin
            r_rvalid[i] <= w_gnt[i] && (w_wea[i] == 4'd0);
            r_psel[i]   <= w_b_vld && (w_b == 2'(i));
         end
      end
   end

   always_comb begin
      w_rdata = 96'd0;
      for (int i = 0; i < 3; i++) begin
         if (r_rvalid[i])
            w_rdata[32*i +: 32] = r_psel[i] ? bus.sram_rdata1 : bus.sram_rdata0;
      end
   end

   assign bus.rvalid = r_rvalid;
   assign bus.rdata  = w_rdata;
endmodule

// File: tb/tb_imag_sram_arbiter.sv
// Testbench for imag_sram_arbiter: vector table, directed sequences, random vs model.
// Ports: none (top-level bench with SRAM model and reference memory).
module tb_imag_sram_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic init_mem = 1'b0;
   always #5 clk = ~clk;

   imag_sram_arbiter_if bus ();
   imag_sram_arbiter #(.DEPTH(480), .NREQ(3)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [2:0]  t_req;
   logic [3:0]  t_wea   [3];
   logic [15:0] t_addr  [3];
   logic [31:0] t_wdata [3];

   assign bus.req   = t_req;
   assign bus.wea   = {t_wea[2], t_wea[1], t_wea[0]};
   assign bus.addr  = {t_addr[2], t_addr[1], t_addr[0]};
   assign bus.wdata = {t_wdata[2], t_wdata[1], t_wdata[0]};

   int n_chk = 0;
   int n_err = 0;

   function automatic logic [31:0] pattern(input int k);
      if (k == 479) return 32'hAABBCCDD;
      return {16'hC0DE, 16'(k)} ^ (32'(k) * 32'h9E3779B1);
   endfunction

   // Dual-port SRAM: read-before-write, byte enables, both ports every cycle.
   logic [31:0] mem [480];
   always @(posedge clk) begin
      if (init_mem) begin
         for (int k = 0; k < 480; k++) mem[k] <= pattern(k);
      end else begin
         bus.sram_rdata0 <= (bus.sram_addr0 < 480) ? mem[bus.sram_addr0] : 32'd0;
         bus.sram_rdata1 <= (bus.sram_addr1 < 480) ? mem[bus.sram_addr1] : 32'd0;
         for (int b = 0; b < 4; b++) begin
            if (bus.sram_wea0[b] && bus.sram_addr0 < 480)
               mem[bus.sram_addr0][8*b +: 8] <= bus.sram_wdata0[8*b +: 8];
            if (bus.sram_wea1[b] && bus.sram_addr1 < 480)
               mem[bus.sram_addr1][8*b +: 8] <= bus.sram_wdata1[8*b +: 8];
         end
      end
   end

   logic [31:0] ref_mem [480];

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic set_in(input logic [2:0] r,
                         input logic [3:0] w0, input logic [3:0] w1, input logic [3:0] w2,
                         input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
      t_req = r;
      t_wea[0] = w0;  t_wea[1] = w1;  t_wea[2] = w2;
      t_addr[0] = a0; t_addr[1] = a1; t_addr[2] = a2;
      t_wdata[0] = d0; t_wdata[1] = d1; t_wdata[2] = d2;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      t_req = 3'b000;
      rst = 1'b1;
      nxt();
      rst = 1'b0;
   endtask

   task automatic do_init();
      init_mem = 1'b1;
      nxt();
      init_mem = 1'b0;
      for (int k = 0; k < 480; k++) ref_mem[k] = pattern(k);
   endtask

   // Reference: queue of requesters in rotation order; head wins port 0,
   // first later entry not hazarding against it wins port 1.
   function automatic void model_grant(input int p, output int ga, output int gb);
      int q[$];
      ga = -1;
      gb = -1;
      for (int k = 0; k < 3; k++)
         if (t_req[(p + k) % 3]) q.push_back((p + k) % 3);
      if (q.size() == 0) return;
      ga = q.pop_front();
      foreach (q[j]) begin
         if (gb < 0) begin
            if (!(t_addr[ga] == t_addr[q[j]] &&
                  (t_wea[ga] != 0 || t_wea[q[j]] != 0)))
               gb = q[j];
         end
      end
   endfunction

   typedef struct {
      logic [2:0]  req;
      logic [3:0]  w0, w1, w2;
      logic [15:0] a0, a1, a2;
      logic [2:0]  g;
      logic [15:0] a1x;
      logic [3:0]  we1x;
   } vec_t;

   vec_t vecs [9];

   int          mptr;
   logic [2:0]  exp_rv;
   logic [31:0] exp_rd [3];
   logic [2:0]  last_g;

   initial begin
      int ga, gb;
      logic [2:0] eg, nrv;
      logic [15:0] ea0;
      vecs[0] = '{3'b001, 4'h0, 4'h0, 4'h0, 16'd3, 16'd0, 16'd0, 3'b001, 16'd3, 4'h0};
      vecs[1] = '{3'b110, 4'h0, 4'h0, 4'h0, 16'd0, 16'd4, 16'd9, 3'b110, 16'd9, 4'h0};
      vecs[2] = '{3'b111, 4'hF, 4'h0, 4'h0, 16'd8, 16'd8, 16'd8, 3'b001, 16'd8, 4'h0};
      vecs[3] = '{3'b111, 4'h0, 4'h1, 4'h0, 16'd8, 16'd8, 16'd9, 3'b101, 16'd9, 4'h0};
      vecs[4] = '{3'b011, 4'h0, 4'h0, 4'h0, 16'd12, 16'd12, 16'd0, 3'b011, 16'd12, 4'h0};
      vecs[5] = '{3'b111, 4'h0, 4'h0, 4'h3, 16'd1, 16'd2, 16'd3, 3'b011, 16'd2, 4'h0};
      vecs[6] = '{3'b000, 4'h0, 4'h0, 4'h0, 16'd7, 16'd8, 16'd9, 3'b000, 16'd0, 4'h0};
      vecs[7] = '{3'b101, 4'hF, 4'h0, 4'h0, 16'd5, 16'd0, 16'd5, 3'b001, 16'd5, 4'h0};
      vecs[8] = '{3'b110, 4'h0, 4'h0, 4'hF, 16'd0, 16'd4, 16'd5, 3'b110, 16'd5, 4'hF};

      set_in(3'b111, 4'hF, 4'h0, 4'h0, 16'd1, 16'd2, 16'd3, 32'h1, 32'h2, 32'h3);
      rst = 1'b1;
      nxt();
      @(negedge clk);
      chk("rst_gnt", 96'(bus.gnt), 96'd0);
      chk("rst_wea", 96'({bus.sram_wea0, bus.sram_wea1}), 96'd0);
      nxt();
      rst = 1'b0;
      t_req = 3'b000;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("idle_gnt", 96'(bus.gnt), 96'd0);
         chk("idle_addr0", 96'(bus.sram_addr0), 96'd0);
         chk("idle_addr1", 96'(bus.sram_addr1), 96'd0);
         chk("idle_wea", 96'({bus.sram_wea0, bus.sram_wea1}), 96'd0);
         chk("idle_rvalid", 96'(bus.rvalid), 96'd0);
      end

      foreach (vecs[v]) begin
         do_reset();
         set_in(vecs[v].req, vecs[v].w0, vecs[v].w1, vecs[v].w2,
                vecs[v].a0, vecs[v].a1, vecs[v].a2, 32'h11, 32'h22, 32'h33);
         @(negedge clk);
         chk($sformatf("vec%0d_gnt", v), 96'(bus.gnt), 96'(vecs[v].g));
         chk($sformatf("vec%0d_addr1", v), 96'(bus.sram_addr1), 96'(vecs[v].a1x));
         chk($sformatf("vec%0d_wea1", v), 96'(bus.sram_wea1), 96'(vecs[v].we1x));
         nxt();
         t_req = 3'b000;
      end

      do_init();
      do_reset();
      set_in(3'b111, 0, 0, 0, 16'd5, 16'd6, 16'd7, 0, 0, 0);
      @(negedge clk);
      chk("rr_gnt0", 96'(bus.gnt), 96'(3'b011));
      nxt();
      @(negedge clk);
      chk("rr_gnt1", 96'(bus.gnt), 96'(3'b101));
      chk("rr_rv1", 96'(bus.rvalid), 96'(3'b011));
      chk("rr_rd1_0", 96'(bus.rdata[31:0]), 96'(pattern(5)));
      chk("rr_rd1_1", 96'(bus.rdata[63:32]), 96'(pattern(6)));
      nxt();
      @(negedge clk);
      chk("rr_gnt2", 96'(bus.gnt), 96'(3'b110));
      chk("rr_rv2", 96'(bus.rvalid), 96'(3'b101));
      chk("rr_rd2_0", 96'(bus.rdata[31:0]), 96'(pattern(5)));
      chk("rr_rd2_2", 96'(bus.rdata[95:64]), 96'(pattern(7)));
      nxt();
      t_req = 3'b000;
      @(negedge clk);
      chk("rr_rv3", 96'(bus.rvalid), 96'(3'b110));
      chk("rr_rd3_2", 96'(bus.rdata[95:64]), 96'(pattern(7)));

      do_reset();
      set_in(3'b111, 4'hF, 0, 0, 16'd10, 16'd10, 16'd20, 32'hDEADBEEF, 0, 0);
      @(negedge clk);
      chk("haz_gnt", 96'(bus.gnt), 96'(3'b101));
      chk("haz_addr1", 96'(bus.sram_addr1), 96'd20);
      nxt();
      t_req = 3'b010;
      @(negedge clk);
      chk("haz_gnt2", 96'(bus.gnt), 96'(3'b010));
      chk("haz_rv2", 96'(bus.rvalid), 96'(3'b100));
      chk("haz_rd2", 96'(bus.rdata[95:64]), 96'(pattern(20)));
      nxt();
      t_req = 3'b000;
      @(negedge clk);
      chk("haz_rv1", 96'(bus.rvalid), 96'(3'b010));
      chk("haz_raw", 96'(bus.rdata[63:32]), 96'(32'hDEADBEEF));

      set_in(3'b011, 0, 0, 0, 16'd33, 16'd33, 16'd0, 0, 0, 0);
      @(negedge clk);
      chk("rr33_gnt", 96'(bus.gnt), 96'(3'b011));
      chk("rr33_addr1", 96'(bus.sram_addr1), 96'd33);
      nxt();
      t_req = 3'b000;
      @(negedge clk);
      chk("rr33_rv", 96'(bus.rvalid), 96'(3'b011));
      chk("rr33_rd0", 96'(bus.rdata[31:0]), 96'(pattern(33)));
      chk("rr33_rd1", 96'(bus.rdata[63:32]), 96'(pattern(33)));

      set_in(3'b100, 0, 0, 4'h3, 0, 0, 16'd479, 0, 0, 32'h12345678);
      @(negedge clk);
      chk("bw_gnt", 96'(bus.gnt), 96'(3'b100));
      chk("bw_p0", 96'({bus.sram_addr0, bus.sram_wea0}), 96'({16'd479, 4'h3}));
      chk("bw_p1", 96'({bus.sram_addr1, bus.sram_wea1}), 96'({16'd479, 4'h0}));
      nxt();
      t_wea[2] = 4'h0;
      @(negedge clk);
      chk("bw_gnt2", 96'(bus.gnt), 96'(3'b100));
      nxt();
      t_req = 3'b000;
      @(negedge clk);
      chk("bw_rv", 96'(bus.rvalid), 96'(3'b100));
      chk("bw_rd", 96'(bus.rdata[95:64]), 96'(32'hAABB5678));

      set_in(3'b001, 0, 0, 0, 16'd1, 16'd2, 16'd3, 0, 0, 0);
      @(negedge clk);
      chk("mr_gnt0", 96'(bus.gnt), 96'(3'b001));
      nxt();
      rst = 1'b1;
      t_req = 3'b011;
      @(negedge clk);
      chk("mr_gnt_rst", 96'(bus.gnt), 96'd0);
      chk("mr_rv_rst", 96'(bus.rvalid), 96'(3'b001));
      nxt();
      rst = 1'b0;
      t_req = 3'b111;
      @(negedge clk);
      chk("mr_rv_after", 96'(bus.rvalid), 96'd0);
      chk("mr_gnt_after", 96'(bus.gnt), 96'(3'b011));
      nxt();
      t_req = 3'b000;
      @(negedge clk);
      chk("mr_rv_next", 96'(bus.rvalid), 96'(3'b011));

      do_init();
      do_reset();
      mptr = 0;
      exp_rv = 3'b000;
      last_g = 3'b111;
      t_req = 3'b000;
      for (int c = 0; c < 500; c++) begin
         for (int i = 0; i < 3; i++) begin
            if (!t_req[i] || last_g[i]) begin
               t_req[i]   = ($urandom % 4) != 0;
               t_addr[i]  = (($urandom % 5) == 0) ? 16'd479 : 16'($urandom % 6);
               t_wea[i]   = (($urandom % 2) == 0) ? 4'h0 : 4'($urandom % 15 + 1);
               t_wdata[i] = $urandom;
            end
         end
         @(negedge clk);
         model_grant(mptr, ga, gb);
         eg = 3'b000;
         if (ga >= 0) eg[ga] = 1'b1;
         if (gb >= 0) eg[gb] = 1'b1;
         ea0 = (ga >= 0) ? t_addr[ga] : 16'd0;
         chk("rnd_gnt", 96'(bus.gnt), 96'(eg));
         chk("rnd_p0", 96'({bus.sram_addr0, bus.sram_wea0, bus.sram_wdata0}),
             96'({ea0, (ga >= 0) ? t_wea[ga] : 4'h0,
                  (ga >= 0) ? t_wdata[ga] : 32'h0}));
         chk("rnd_p1", 96'({bus.sram_addr1, bus.sram_wea1, bus.sram_wdata1}),
             96'({(gb >= 0) ? t_addr[gb] : ea0, (gb >= 0) ? t_wea[gb] : 4'h0,
                  (gb >= 0) ? t_wdata[gb] : 32'h0}));
         chk("rnd_rvalid", 96'(bus.rvalid), 96'(exp_rv));
         for (int i = 0; i < 3; i++)
            if (exp_rv[i])
               chk($sformatf("rnd_rdata%0d", i), 96'(bus.rdata[32*i +: 32]),
                   96'(exp_rd[i]));
         nrv = 3'b000;
         for (int i = 0; i < 3; i++) begin
            if (eg[i] && t_wea[i] == 4'h0) begin
               nrv[i] = 1'b1;
               exp_rd[i] = ref_mem[t_addr[i]];
            end
         end
         for (int i = 0; i < 3; i++)
            if (eg[i])
               for (int b = 0; b < 4; b++)
                  if (t_wea[i][b]) ref_mem[t_addr[i]][8*b +: 8] = t_wdata[i][8*b +: 8];
         exp_rv = nrv;
         if (ga >= 0) mptr = (((gb >= 0) ? gb : ga) + 1) % 3;
         last_g = eg;
         nxt();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/imag_sram_arbiter.md
Name: imag_sram_arbiter

Overview:
- Shares the dual-port 480x32b imaginary-part SRAM between three requesters: host loader, compute engine and result unloader.
- Grants up to two accesses per cycle, one on each SRAM port, using rotating priority.
- Resolves same-address hazards so that no write is lost.
- Returns read data with a per-requester valid one cycle after the grant.

Parameters:
- DEPTH, 480, number of SRAM words; used only by bench checks, addresses are passed through unchanged.
- NREQ, 3, number of requesters; fixed at 3 in this version.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  3  request, one bit per requester i
- wea  in  12  byte write enable, bits [4i+3:4i]; 0 means read
- addr  in  48  word address, bits [16i+15:16i]
- wdata  in  96  write data, bits [32i+31:32i]
- gnt  out  3  combinational grant; the access is issued to the SRAM this cycle
- rvalid  out  3  read data valid for requester i
- rdata  out  96  read data, bits [32i+31:32i]
- sram_wea0  out  4  SRAM port 0 byte enable
- sram_addr0  out  16  SRAM port 0 address
- sram_wdata0  out  32  SRAM port 0 write data
- sram_rdata0  in  32  SRAM port 0 read data
- sram_wea1  out  4  SRAM port 1 byte enable
- sram_addr1  out  16  SRAM port 1 address
- sram_wdata1  out  32  SRAM port 1 write data
- sram_rdata1  in  32  SRAM port 1 read data

Behaviour:
- State:
  - 2-bit rotating pointer ptr, values 0..2.
  - Registered rvalid[2:0].
  - Registered port-select psel[i] per requester.
- Reset, when rst=1 at posedge clk: ptr=0, rvalid=0, psel=0. While rst=1: gnt=0 and both sram_wea=0.
- Search order each cycle: ptr, ptr+1, ptr+2, all mod 3.
- First requesting index A goes to port 0.
- Next requesting index B in order goes to port 1 unless B conflicts with A.
  - Conflict: addr_A==addr_B and (wea_A!=0 or wea_B!=0).
  - On conflict, B is skipped and the remaining index C is tried under the same rule against A.
  - Two reads to the same address never conflict; both are granted.
- A skipped requester keeps its req and inputs stable until granted. gnt is combinational from req, addr, wea and ptr.
- Port 0 drives the inputs of A. With no grant: sram_addr0=0, sram_wea0=0, sram_wdata0=0.
- Port 1 drives the inputs of the second grantee. With no second grant: sram_addr1=sram_addr0, sram_wea1=0, sram_wdata1=0.
  - This is mandatory. The SRAM rewrites the current word on every port each cycle, so an idle port aimed at another address would corrupt a concurrent write.
- Pointer update: if any grant, ptr <= (last granted index + 1) mod 3; otherwise ptr is unchanged.
  - With all three requesting continuously, grants cycle {0,1}, {2,0}, {1,2} and repeat.
- Read return:
  - For each granted requester with wea==0: next cycle rvalid[i]=1 and psel[i]=port used.
  - rdata[i] = psel[i] ? sram_rdata1 : sram_rdata0, combinational, valid while rvalid[i]=1. The SRAM output settles half a cycle after the edge.
  - rvalid is a single-cycle pulse per granted read.
  - A granted write (any wea bit set) produces no rvalid.
  - rdata[i] while rvalid[i]=0 is don't-care; implementation drives 0.
- Back-to-back grants to the same requester each produce their own rvalid pulse in the following cycle. There is no outstanding-count limit.
- Read after write to the same address in the next cycle returns the new data; the SRAM write completes before the read edge.
- Reset mid-operation: rvalid pulses scheduled by grants in the reset cycle are suppressed, and ptr returns to 0.

Test Plan:
- Reset, then all req=0 -> gnt=000; sram_addr0=sram_addr1=0; both wea=0; rvalid=000 for 10 cycles.
- After reset, req=111, all reads, addrs 5/6/7 -> gnt=011, 101, 110 on successive cycles. Next cycle rvalid matches; each rdata equals the preloaded word at its address.
- ptr=0, req0 write 0xDEADBEEF wea=F at addr 10, req1 read addr 10, req2 read addr 20 -> gnt=101. req1 is granted next cycle and reads 0xDEADBEEF.
- req0 and req1 both read addr 33 -> gnt=011 same cycle; both rvalid next cycle with identical rdata.
- req2 only, write wea=0011 0x12345678 to addr 479 holding 0xAABBCCDD -> sram_addr1=479, sram_wea1=0. Readback gives 0xAABB5678.
- Assert rst in the cycle req=011 is granted -> no rvalid next cycle; ptr=0; first post-reset grant favours requester 0.
